// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StJal,
    StBranch
  } mc_state_t;

  // ALUOp: what the ALU decoder is asked to do
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [2:0] AluCtlAdd = 3'b000;
  localparam logic [2:0] AluCtlSub = 3'b001;
  localparam logic [2:0] AluCtlAnd = 3'b010;
  localparam logic [2:0] AluCtlOr  = 3'b011;
  localparam logic [2:0] AluCtlSlt = 3'b101;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] Funct3Beq = 3'b000;
  localparam logic [2:0] Funct3Bne = 3'b001;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: ALUOp plus instruction fields to ALUControl.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // Fixed add/sub for address and branch math, funct3 decode for ALU instructions
  always_comb begin
    alu_control_o = AluCtlAdd;
    case (alu_op_i)
      AluOpAdd: alu_control_o = AluCtlAdd;
      AluOpSub: alu_control_o = AluCtlSub;
      AluOpFunct: begin
        case (funct3_i)
          // only R-type (op5=1) with funct7b5 is sub; addi ignores funct7b5
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? AluCtlSub : AluCtlAdd;
          3'b010:  alu_control_o = AluCtlSlt;
          3'b110:  alu_control_o = AluCtlOr;
          3'b111:  alu_control_o = AluCtlAnd;
          default: alu_control_o = AluCtlAdd;
        endcase
      end
      default: alu_control_o = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control unit for the RV32I core: Moore FSM sequencing the shared datapath.
// Optional MC_CTRL_MEM_WAIT_EN adds a MemReady input that stalls FETCH/MEMREAD/MEMWRITE.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       i_mc_ctrl_clk,
  input  logic       i_mc_ctrl_rst_n,
  input  logic [6:0] i_mc_ctrl_op,
  input  logic [2:0] i_mc_ctrl_funct3,
  input  logic       i_mc_ctrl_funct7b5,
  input  logic       i_mc_ctrl_Zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic       i_mc_ctrl_MemReady,
`endif
  output logic       o_mc_ctrl_PCWrite,
  output logic       o_mc_ctrl_AdrSrc,
  output logic       o_mc_ctrl_MemWrite,
  output logic       o_mc_ctrl_IRWrite,
  output logic       o_mc_ctrl_RegWrite,
  output logic [1:0] o_mc_ctrl_ResultSrc,
  output logic [1:0] o_mc_ctrl_ALUSrcA,
  output logic [1:0] o_mc_ctrl_ALUSrcB,
  output logic [2:0] o_mc_ctrl_ALUControl,
  output logic [1:0] o_mc_ctrl_ImmSrc,
  output logic       o_mc_ctrl_Illegal
);

  mc_state_t  state_q, state_d;
  logic       mem_ready;
  logic       pc_update, branch, taken;
  logic       ir_write, reg_write, mem_write, illegal;
  logic [1:0] alu_op;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ready = i_mc_ctrl_MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge i_mc_ctrl_clk or negedge i_mc_ctrl_rst_n) begin
    if (!i_mc_ctrl_rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d             = state_q;
    pc_update           = 1'b0;
    branch              = 1'b0;
    ir_write            = 1'b0;
    reg_write           = 1'b0;
    mem_write           = 1'b0;
    illegal             = 1'b0;
    o_mc_ctrl_AdrSrc    = 1'b0;
    o_mc_ctrl_ResultSrc = ResAluOut;
    o_mc_ctrl_ALUSrcA   = SrcAPc;
    o_mc_ctrl_ALUSrcB   = SrcBRs2;
    alu_op              = AluOpAdd;
    case (state_q)
      StFetch: begin
        o_mc_ctrl_ALUSrcA   = SrcAPc;
        o_mc_ctrl_ALUSrcB   = SrcBFour;
        o_mc_ctrl_ResultSrc = ResAluResult;
        ir_write            = mem_ready;
        pc_update           = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // OldPC + imm: branch/jump target is ready in ALUOut by the next state
        o_mc_ctrl_ALUSrcA = SrcAOldPc;
        o_mc_ctrl_ALUSrcB = SrcBImm;
        case (i_mc_ctrl_op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = StBranch;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        o_mc_ctrl_ALUSrcA = SrcARs1;
        o_mc_ctrl_ALUSrcB = SrcBImm;
        state_d = i_mc_ctrl_op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        o_mc_ctrl_ResultSrc = ResAluOut;
        o_mc_ctrl_AdrSrc    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        o_mc_ctrl_ResultSrc = ResData;
        reg_write           = 1'b1;
        state_d             = StFetch;
      end
      StMemWrite: begin
        o_mc_ctrl_ResultSrc = ResAluOut;
        o_mc_ctrl_AdrSrc    = 1'b1;
        mem_write           = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecuteR: begin
        o_mc_ctrl_ALUSrcA = SrcARs1;
        o_mc_ctrl_ALUSrcB = SrcBRs2;
        alu_op            = AluOpFunct;
        state_d           = StAluWb;
      end
      StExecuteI: begin
        o_mc_ctrl_ALUSrcA = SrcARs1;
        o_mc_ctrl_ALUSrcB = SrcBImm;
        alu_op            = AluOpFunct;
        state_d           = StAluWb;
      end
      StAluWb: begin
        o_mc_ctrl_ResultSrc = ResAluOut;
        reg_write           = 1'b1;
        state_d             = StFetch;
      end
      StJal: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd
        o_mc_ctrl_ALUSrcA   = SrcAOldPc;
        o_mc_ctrl_ALUSrcB   = SrcBFour;
        o_mc_ctrl_ResultSrc = ResAluOut;
        pc_update           = 1'b1;
        state_d             = StAluWb;
      end
      StBranch: begin
        o_mc_ctrl_ALUSrcA   = SrcARs1;
        o_mc_ctrl_ALUSrcB   = SrcBRs2;
        o_mc_ctrl_ResultSrc = ResAluOut;
        alu_op              = AluOpSub;
        branch              = 1'b1;
        state_d             = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Branch condition from the subtract result
  always_comb begin
    case (i_mc_ctrl_funct3)
      Funct3Beq: taken = i_mc_ctrl_Zero;
      Funct3Bne: taken = ~i_mc_ctrl_Zero;
      default:   taken = 1'b0;
    endcase
  end

  // Immediate format depends only on the opcode
  always_comb begin
    case (i_mc_ctrl_op)
      OpStore:  o_mc_ctrl_ImmSrc = ImmS;
      OpBranch: o_mc_ctrl_ImmSrc = ImmB;
      OpJal:    o_mc_ctrl_ImmSrc = ImmJ;
      default:  o_mc_ctrl_ImmSrc = ImmI;
    endcase
  end

  // Strobes are killed combinationally so an asserted reset aborts any write at once
  assign o_mc_ctrl_PCWrite  = i_mc_ctrl_rst_n & (pc_update | (branch & taken));
  assign o_mc_ctrl_IRWrite  = i_mc_ctrl_rst_n & ir_write;
  assign o_mc_ctrl_RegWrite = i_mc_ctrl_rst_n & reg_write;
  assign o_mc_ctrl_MemWrite = i_mc_ctrl_rst_n & mem_write;
  assign o_mc_ctrl_Illegal  = i_mc_ctrl_rst_n & illegal;

  mc_alu_dec u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (i_mc_ctrl_funct3),
    .op5_i         (i_mc_ctrl_op[5]),
    .funct7b5_i    (i_mc_ctrl_funct7b5),
    .alu_control_o (o_mc_ctrl_ALUControl)
  );

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: vector table, hand sequences and random instruction stream.
module tb_mc_ctrl;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, zero, ready;
  logic       pcw, adr, mw, irw, rw, ill;
  logic [1:0] rs, sa, sb, imm;
  logic [2:0] alu;

  int tests = 0;
  int fails = 0;

  mc_ctrl dut (
    .i_mc_ctrl_clk        (clk),
    .i_mc_ctrl_rst_n      (rst_n),
    .i_mc_ctrl_op         (op),
    .i_mc_ctrl_funct3     (f3),
    .i_mc_ctrl_funct7b5   (f7),
    .i_mc_ctrl_Zero       (zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .i_mc_ctrl_MemReady   (ready),
`endif
    .o_mc_ctrl_PCWrite    (pcw),
    .o_mc_ctrl_AdrSrc     (adr),
    .o_mc_ctrl_MemWrite   (mw),
    .o_mc_ctrl_IRWrite    (irw),
    .o_mc_ctrl_RegWrite   (rw),
    .o_mc_ctrl_ResultSrc  (rs),
    .o_mc_ctrl_ALUSrcA    (sa),
    .o_mc_ctrl_ALUSrcB    (sb),
    .o_mc_ctrl_ALUControl (alu),
    .o_mc_ctrl_ImmSrc     (imm),
    .o_mc_ctrl_Illegal    (ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
  } outs_t;

  typedef struct packed {
    outs_t v;
    outs_t m;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         z;
    int         k;
    string      exp;
    string      nm;
  } vec_t;

  function automatic outs_t get_outs();
    outs_t o;
    o.pcw = pcw; o.adr = adr; o.mw = mw; o.irw = irw; o.rw = rw; o.ill = ill;
    o.rs = rs; o.sa = sa; o.sb = sb; o.alu = alu; o.imm = imm;
    return o;
  endfunction

  // Pattern string, MSB first in outs_t order: '0'/'1' required, '-' don't care, '_' ignored
  function automatic exp_t parse(string s);
    logic [16:0] vv, vm;
    int b;
    exp_t e;
    vv = '0; vm = '0; b = 16;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] != "_") begin
        if (s[i] != "-") begin
          vm[b] = 1'b1;
          vv[b] = (s[i] == "1");
        end
        b--;
      end
    end
    e.v = outs_t'(vv);
    e.m = outs_t'(vm);
    return e;
  endfunction

  // ---- reference model: instruction class -> sequence of datapath steps ----
  // F fetch, D decode, A address, R mem read, L load writeback, S mem write,
  // X reg-reg execute, I reg-imm execute, W ALU writeback, J jump, B branch
  function automatic string steps_for(logic [6:0] o);
    case (o)
      7'b0000011: return "FDARL";
      7'b0100011: return "FDAS";
      7'b0110011: return "FDXW";
      7'b0010011: return "FDIW";
      7'b1101111: return "FDJW";
      7'b1100011: return "FDB";
      default:    return "FD";
    endcase
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // add=0 sub=1 and=2 or=3 slt=5
  function automatic logic [2:0] alu_funct(logic [2:0] fn3, logic op5, logic fb5);
    if (fn3 == 3'd0) return (op5 && fb5) ? 3'd1 : 3'd0;
    if (fn3 == 3'd2) return 3'd5;
    if (fn3 == 3'd6) return 3'd3;
    if (fn3 == 3'd7) return 3'd2;
    return 3'd0;
  endfunction

  function automatic exp_t model(byte s, logic [6:0] o, logic [2:0] fn3, logic fb5,
                                 logic z, logic rdy);
    exp_t e;
    e.v = '0; e.m = '0;
    e.m.pcw = 1'b1; e.m.mw = 1'b1; e.m.irw = 1'b1; e.m.rw = 1'b1; e.m.ill = 1'b1;
    e.m.imm = 2'b11; e.v.imm = imm_of(o);
    case (s)
      "F": begin
        e.m.adr = 1'b1; e.v.adr = 1'b0;
        e.v.irw = rdy; e.v.pcw = rdy;
        e.m.sa = 2'b11; e.v.sa = 2'd0; e.m.sb = 2'b11; e.v.sb = 2'd2;
        e.m.alu = 3'b111; e.v.alu = 3'd0; e.m.rs = 2'b11; e.v.rs = 2'd2;
      end
      "D": begin
        e.m.sa = 2'b11; e.v.sa = 2'd1; e.m.sb = 2'b11; e.v.sb = 2'd1;
        e.m.alu = 3'b111; e.v.alu = 3'd0;
        e.v.ill = (steps_for(o).len() == 2);
      end
      "A": begin
        e.m.sa = 2'b11; e.v.sa = 2'd2; e.m.sb = 2'b11; e.v.sb = 2'd1;
        e.m.alu = 3'b111; e.v.alu = 3'd0;
      end
      "R": begin
        e.m.rs = 2'b11; e.v.rs = 2'd0; e.m.adr = 1'b1; e.v.adr = 1'b1;
      end
      "L": begin
        e.m.rs = 2'b11; e.v.rs = 2'd1; e.v.rw = 1'b1;
      end
      "S": begin
        e.m.rs = 2'b11; e.v.rs = 2'd0; e.m.adr = 1'b1; e.v.adr = 1'b1; e.v.mw = 1'b1;
      end
      "X", "I": begin
        e.m.sa = 2'b11; e.v.sa = 2'd2; e.m.sb = 2'b11; e.v.sb = (s == "X") ? 2'd0 : 2'd1;
        e.m.alu = 3'b111; e.v.alu = alu_funct(fn3, o[5], fb5);
      end
      "W": begin
        e.m.rs = 2'b11; e.v.rs = 2'd0; e.v.rw = 1'b1;
      end
      "J": begin
        e.m.sa = 2'b11; e.v.sa = 2'd1; e.m.sb = 2'b11; e.v.sb = 2'd2;
        e.m.alu = 3'b111; e.v.alu = 3'd0; e.m.rs = 2'b11; e.v.rs = 2'd0; e.v.pcw = 1'b1;
      end
      "B": begin
        e.m.sa = 2'b11; e.v.sa = 2'd2; e.m.sb = 2'b11; e.v.sb = 2'd0;
        e.m.alu = 3'b111; e.v.alu = 3'd1; e.m.rs = 2'b11; e.v.rs = 2'd0;
        e.v.pcw = (fn3 == 3'd0) ? z : (fn3 == 3'd1) ? !z : 1'b0;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(string nm, byte s, exp_t e);
    logic [16:0] a, v, m;
    a = get_outs();
    v = e.v;
    m = e.m;
    tests++;
    if (((a ^ v) & m) != 17'd0) begin
      fails++;
      $display("FAIL %s step %c: got %b required %b (care %b)", nm, s, a, v, m);
    end
  endtask

  task automatic check_val(string nm, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // Runs one instruction from FETCH; called at posedge+1 with the FSM in FETCH.
  // chk_k < 0: every step against the model; otherwise only step chk_k against chk_s.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] fn3, input logic fb5,
                           input int zmode, input int chk_k, input string chk_s,
                           input string nm);
    string st;
    bit    held;
    int    waits;
    st = steps_for(o);
    op = o; f3 = fn3; f7 = fb5;
    for (int k = 0; k < st.len(); k++) begin
      waits = 0;
      do begin
        zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        ready = 1'b1;
`ifdef MC_CTRL_MEM_WAIT_EN
        if (chk_k < 0 && (st[k] == "F" || st[k] == "R" || st[k] == "S") && waits < 3)
          ready = 1'($urandom_range(0, 1));
`endif
        @(negedge clk);
        if (chk_k < 0) check(nm, st[k], model(st[k], o, fn3, fb5, zero, ready));
        else if (k == chk_k) check(nm, st[k], parse(chk_s));
        held = !ready;
        waits++;
        @(posedge clk);
        #1;
      end while (held);
    end
  endtask

  vec_t vecs[$];
  int   cnt, at;
  logic [6:0] rop;

  initial begin
    vecs.push_back('{7'b0000011, 3'd2, 1'b0, 0, 0, "100100_10_00_10_000_00", "lw_fetch"});
    vecs.push_back('{7'b0000011, 3'd2, 1'b0, 0, 1, "0-0000_--_01_01_000_00", "lw_decode"});
    vecs.push_back('{7'b0000011, 3'd2, 1'b0, 0, 2, "0-0000_--_10_01_000_00", "lw_memadr"});
    vecs.push_back('{7'b0000011, 3'd2, 1'b0, 0, 3, "010000_00_--_--_---_00", "lw_memread"});
    vecs.push_back('{7'b0000011, 3'd2, 1'b0, 0, 4, "0-0010_01_--_--_---_00", "lw_memwb"});
    vecs.push_back('{7'b0100011, 3'd2, 1'b0, 0, 3, "011000_00_--_--_---_01", "sw_memwrite"});
    vecs.push_back('{7'b0110011, 3'd0, 1'b1, 0, 2, "0-0000_--_10_00_001_00", "sub_exec"});
    vecs.push_back('{7'b0110011, 3'd0, 1'b0, 0, 2, "0-0000_--_10_00_000_00", "add_exec"});
    vecs.push_back('{7'b0110011, 3'd5, 1'b1, 0, 2, "0-0000_--_10_00_000_00", "sra_as_add"});
    vecs.push_back('{7'b0110011, 3'd6, 1'b0, 0, 2, "0-0000_--_10_00_011_00", "or_exec"});
    vecs.push_back('{7'b0010011, 3'd0, 1'b1, 0, 2, "0-0000_--_10_01_000_00", "addi_f7"});
    vecs.push_back('{7'b0010011, 3'd2, 1'b0, 0, 2, "0-0000_--_10_01_101_00", "slti_exec"});
    vecs.push_back('{7'b0010011, 3'd7, 1'b0, 0, 2, "0-0000_--_10_01_010_00", "andi_exec"});
    vecs.push_back('{7'b1100011, 3'd0, 1'b0, 1, 2, "1-0000_00_10_00_001_10", "beq_taken"});
    vecs.push_back('{7'b1100011, 3'd0, 1'b0, 0, 2, "0-0000_00_10_00_001_10", "beq_not"});
    vecs.push_back('{7'b1100011, 3'd1, 1'b0, 0, 2, "1-0000_00_10_00_001_10", "bne_taken"});
    vecs.push_back('{7'b1100011, 3'd1, 1'b0, 1, 2, "0-0000_00_10_00_001_10", "bne_not"});
    vecs.push_back('{7'b1100011, 3'd4, 1'b0, 1, 2, "0-0000_00_10_00_001_10", "blt_never"});
    vecs.push_back('{7'b1101111, 3'd0, 1'b0, 0, 2, "1-0000_00_01_10_000_11", "jal_jump"});
    vecs.push_back('{7'b1101111, 3'd0, 1'b0, 0, 3, "0-0010_00_--_--_---_11", "jal_wb"});
    vecs.push_back('{7'b0000000, 3'd0, 1'b0, 0, 1, "0-0001_--_01_01_000_00", "illegal_dec"});

    // Reset held three cycles
    rst_n = 1'b0; op = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", "F", parse("000000_10_00_10_000_00"));
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("release", "F", parse("100100_10_00_10_000_00"));

    foreach (vecs[i])
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].k, vecs[i].exp,
                vecs[i].nm);

    // sw: exactly one MemWrite cycle, in cycle 4
    op = 7'b0100011; f3 = 3'd2; zero = 1'b0; cnt = 0; at = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (mw) begin cnt++; at = c; end
      @(posedge clk); #1;
    end
    check_val("sw_memwrite_count", cnt, 1);
    check_val("sw_memwrite_cycle", at, 4);

    // Illegal opcode pulses once and returns to FETCH
    op = 7'b0000000; cnt = 0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (ill) cnt++;
      @(posedge clk); #1;
    end
    op = 7'b0110011;
    @(negedge clk);
    check_val("illegal_pulses", cnt, 1);
    check_val("illegal_refetch", {31'd0, irw}, 1);
    check_val("illegal_low_after", {31'd0, ill}, 0);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end

    // Reset asserted during MEMWRITE kills the write immediately
    op = 7'b0100011;
    repeat (3) begin @(posedge clk); #1; end
    check_val("sw_pre_reset_mw", {31'd0, mw}, 1);
    #2 rst_n = 1'b0;
    #1 check_val("abort_mw", {31'd0, mw}, 0);
    check_val("abort_adrsrc", {31'd0, adr}, 0);
    check_val("abort_irw", {31'd0, irw}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_val("abort_refetch", {31'd0, irw}, 1);

`ifdef MC_CTRL_MEM_WAIT_EN
    // lw with MemReady low for two MEMREAD cycles: read held 3 cycles, writeback in cycle 7
    op = 7'b0000011; f3 = 3'd2; cnt = 0; at = 0;
    for (int c = 1; c <= 7; c++) begin
      ready = (c == 4 || c == 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (adr && rs == 2'b00 && !mw) cnt++;
      if (rw) at = c;
      @(posedge clk); #1;
    end
    ready = 1'b1;
    check_val("wait_memread_cycles", cnt, 3);
    check_val("wait_lw_latency", at, 7);
`endif

    // Random instruction stream against the model
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1101111;
        5: rop = 7'b1100011;
        default: rop = 7'($urandom);
      endcase
      run_instr(rop, 3'($urandom), 1'($urandom), 2, -1, "", "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
